pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/redirect controller driving per-register stall/bubble/branch controls.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int NSTAGE = 4,
  parameter int EX_IDX = 2,
  parameter int ADDR_W = 64,
  parameter int FLUSH_WAIT = 1,
  parameter logic [ADDR_W-1:0] INVALID_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_data_valid_i,
  input  logic                  dcache_data_valid_i,
  input  logic                  id_load_use_i,
  input  logic                  ex_redirect_i,
  input  logic [ADDR_W-1:0]     ex_pc_new_i,
  output logic [1:0]            ctrl_signal_pc_o,
  output logic [2*NSTAGE-1:0]   ctrl_signal_stage_o,
  output logic [ADDR_W-1:0]     ctrl_to_pc_new_o,
  output logic                  ctrl_busy_o,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_redirect_cnt_o
);
  localparam logic [1:0] C_DEF = 2'b00;
  localparam logic [1:0] C_STL = 2'b01;
  localparam logic [1:0] C_BUB = 2'b10;
  localparam logic [1:0] C_BRA = 2'b11;
  localparam logic [3:0] WAIT_LOAD = (FLUSH_WAIT > 0) ? 4'(FLUSH_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, REDIRECT, WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= INVALID_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // A memory stall freezes all control state; nothing else is looked at.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (dcache_data_valid_i) begin
      if (state_q == REDIRECT) begin
        state_d = (FLUSH_WAIT > 0) ? WAIT : IDLE;
        cnt_d   = WAIT_LOAD;
      end else if (state_q == WAIT) begin
        state_d = (cnt_q == 4'd0) ? IDLE : WAIT;
        cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end else if (ex_redirect_i) begin
        state_d = REDIRECT;
        tgt_d   = ex_pc_new_i;
      end
    end
  end

  always_comb begin
    ctrl_signal_pc_o    = C_DEF;
    ctrl_signal_stage_o = '0;
    if (!dcache_data_valid_i) begin
      ctrl_signal_pc_o = C_STL;
      for (int k = 0; k < NSTAGE; k++) ctrl_signal_stage_o[2*k +: 2] = (k == NSTAGE - 1) ? C_BUB : C_STL;
    end else if (state_q == REDIRECT) begin
      ctrl_signal_pc_o = C_BRA;
      for (int k = 0; k < EX_IDX; k++) ctrl_signal_stage_o[2*k +: 2] = C_BUB;
    end else if (state_q == WAIT) begin
      ctrl_signal_stage_o[1:0] = C_BUB;
    end else if (ex_redirect_i) begin
      ctrl_signal_pc_o = C_STL;
      for (int k = 0; k <= EX_IDX; k++) ctrl_signal_stage_o[2*k +: 2] = (k == EX_IDX) ? C_BUB : C_STL;
    end else if (id_load_use_i) begin
      ctrl_signal_pc_o         = C_STL;
      ctrl_signal_stage_o[1:0] = C_STL;
      ctrl_signal_stage_o[3:2] = C_BUB;
    end else if (!icache_data_valid_i) begin
      ctrl_signal_pc_o         = C_STL;
      ctrl_signal_stage_o[1:0] = C_BUB;
    end
  end

  assign ctrl_to_pc_new_o = (state_q == IDLE) ? INVALID_PC : tgt_q;
  assign ctrl_busy_o      = (state_q != IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, redir_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      stall_q <= (ctrl_signal_pc_o == C_STL && stall_q != '1) ? stall_q + 32'd1 : stall_q;
      redir_q <= (state_q == IDLE && state_d == REDIRECT && redir_q != '1) ? redir_q + 32'd1 : redir_q;
    end
  end
  assign perf_stall_cnt_o    = stall_q;
  assign perf_redirect_cnt_o = redir_q;
`else
  assign perf_stall_cnt_o    = '0;
  assign perf_redirect_cnt_o = '0;
`endif
endmodule
